// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and win-line table for the tic-tac-toe controller
// Contents: state_e, result_e, NUM_CELLS, WIN_LINES (3 rows, 3 columns, 2 diagonals).
package ttt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        X_WIN = 2'b01,
        O_WIN = 2'b10,
        DRAW  = 2'b11
    } result_e;

    localparam int NUM_CELLS = 9;

    // Cell indices are row-major: 0 = top-left, 8 = bottom-right.
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// rtl/ttt_game_ctrl_if.sv - move-entry handshake between front end and game controller
// Signals: move_valid (front end -> ctrl), move_pos[3:0] (front end -> ctrl), move_ready (ctrl -> front end).
// Modports: master = move source (keypad/UART decoder), slave = game controller.
interface ttt_game_ctrl_if;

    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;

    modport master (
        output move_valid,
        output move_pos,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_pos,
        output move_ready
    );

endinterface

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational three-in-a-line detector for one board
// Ports: board[8:0] in (bit i = cell i occupied by this player), win out (any WIN_LINES line complete).
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] board,
    output logic                 win
);

    logic [7:0] hit;

    for (genvar i = 0; i < 8; i++) begin : g_line
        assign hit[i] = board[WIN_LINES[i][0]] & board[WIN_LINES[i][1]] & board[WIN_LINES[i][2]];
    end

    assign win = |hit;

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game controller: move handshake, turn order, board registers, win/draw
// Ports: clk, rst_n (sync, active-low), start (new game / abort), mv (slave move handshake),
//        move_reject (1-cycle illegal-move pulse), x/o boards, turn, move_count, game_over, result, timeout.
// Parameters: FIRST_PLAYER (0 = X, 1 = O), TIMEOUT_CYCLES (idle forfeit limit, >= 2).
// Optional feature macro: MOVE_TIMEOUT_EN (per-move idle forfeit; timeout tied 0 when undefined).
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER   = 1'b0,
    parameter int   TIMEOUT_CYCLES = 1000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    ttt_game_ctrl_if.slave       mv,
    output logic                 move_reject,
    output logic [NUM_CELLS-1:0] x,
    output logic [NUM_CELLS-1:0] o,
    output logic                 turn,
    output logic [3:0]           move_count,
    output logic                 game_over,
    output logic [1:0]           result,
    output logic                 timeout
);

    state_e state;
    logic   move_ready_q;

    assign mv.move_ready = move_ready_q;

    // move_ready_q is high exactly while in PLAY, so this is the accepted-move strobe.
    logic handshake;
    assign handshake = mv.move_valid & move_ready_q;

    // Upper one-hot bits flag positions 9..15; lower bits select the target cell.
    logic [15:0]          pos_onehot;
    logic [NUM_CELLS-1:0] cell_mask;
    logic                 illegal;

    assign pos_onehot = 16'd1 << mv.move_pos;
    assign cell_mask  = pos_onehot[NUM_CELLS-1:0];
    assign illegal    = (|pos_onehot[15:NUM_CELLS]) | (|(cell_mask & (x | o)));

    logic x_win;
    logic o_win;
    logic mover_win;

    ttt_line_check u_x_check (.board(x), .win(x_win));
    ttt_line_check u_o_check (.board(o), .win(o_win));

    // Only the player who just moved can have completed a line.
    assign mover_win = turn ? o_win : x_win;

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`else
    wire [31:0] unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            o            <= '0;
            turn         <= FIRST_PLAYER;
            move_count   <= 4'd0;
            move_ready_q <= 1'b0;
            move_reject  <= 1'b0;
            game_over    <= 1'b0;
            result       <= NONE;
            timeout      <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            move_reject <= 1'b0;
            if (start) begin
                // Start overrides everything, including a move presented this cycle.
                state        <= PLAY;
                x            <= '0;
                o            <= '0;
                turn         <= FIRST_PLAYER;
                move_count   <= 4'd0;
                move_ready_q <= 1'b1;
                game_over    <= 1'b0;
                result       <= NONE;
                timeout      <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
                idle_cnt     <= '0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    PLAY: begin
                        if (handshake) begin
`ifdef MOVE_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                            if (illegal) begin
                                move_reject <= 1'b1;
                            end else begin
                                if (turn) o <= o | cell_mask;
                                else      x <= x | cell_mask;
                                move_count   <= move_count + 4'd1;
                                move_ready_q <= 1'b0;
                                state        <= CHECK;
                            end
                        end
`ifdef MOVE_TIMEOUT_EN
                        else if (idle_cnt == IDLE_LAST) begin
                            // Forfeit: the player to move loses.
                            state        <= DONE;
                            move_ready_q <= 1'b0;
                            game_over    <= 1'b1;
                            result       <= turn ? X_WIN : O_WIN;
                            timeout      <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
`endif
                    end
                    CHECK: begin
                        // Win is tested before the full-board draw so a 9th-move win is reported.
                        if (mover_win) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            result    <= turn ? O_WIN : X_WIN;
                        end else if (move_count == 4'd9) begin
                            state     <= DONE;
                            game_over <= 1'b1;
                            result    <= DRAW;
                        end else begin
                            state        <= PLAY;
                            turn         <= ~turn;
                            move_ready_q <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                            idle_cnt     <= '0;
`endif
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
